// File: rtl/sync_tx_arb_pkg.sv
// Shared types and sizing helpers for the synchronizer-channel transmit arbiter.
package sync_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the shared HOLD/GAP down-counter.
  function automatic int unsigned cnt_w(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_tx_rr_pick.sv
// Combinational round-robin picker: one-hot winner and its index, searching from
// last_grant_i+1 upward with wrap-around.
module sync_tx_rr_pick
  import sync_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    pos      = 0;
    pos_idx  = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      pos = int'(last_grant_i) + k;
      if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
      pos_idx = IDX_W'(pos);
      if (req_valid_i[pos_idx]) begin
        onehot_o          = '0;
        onehot_o[pos_idx] = 1'b1;
        idx_o             = pos_idx;
      end
    end
  end

endmodule

// File: rtl/sync_tx_arbiter.sv
// Round-robin arbiter sharing one bus synchronizer channel among NUM_REQ requesters.
// SYNC_TX_ARB_ACK_EN adds a tx_ack_i 4-phase handshake on top of the timed HOLD/GAP.
module sync_tx_arbiter
  import sync_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 3,
  localparam int unsigned IDX_W = idx_w(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [BUS_WIDTH-1:0]         tx_bus_o,
  output logic                         tx_enable_o,
  output logic [IDX_W-1:0]             grant_id_o,
  output logic                         busy_o
`ifdef SYNC_TX_ARB_ACK_EN
  ,
  input  logic                         tx_ack_i
`endif
);

  localparam int unsigned CNT_W = cnt_w(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]   tx_bus_q, tx_bus_d;
  logic                   tx_en_q, tx_en_d;
  logic                   busy_q, busy_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic [BUS_WIDTH-1:0]   req_word [NUM_REQ];
  logic                   hold_done, gap_done;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign req_word[gi] = req_data_i[gi*BUS_WIDTH +: BUS_WIDTH];
  end

  sync_tx_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid_i  (req_valid_i),
    .last_grant_i (last_q),
    .onehot_o     (pick_onehot),
    .idx_o        (pick_idx)
  );

`ifdef SYNC_TX_ARB_ACK_EN
  logic [1:0] ack_sync_q;
  logic       ack_s;

  // Two-flop synchronizer for the acknowledge level returned from the destination.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ack_sync_q <= '0;
    else       ack_sync_q <= {ack_sync_q[0], tx_ack_i};
  end

  assign ack_s     = ack_sync_q[1];
  assign hold_done = (cnt_q == '0) && ack_s;
  assign gap_done  = (cnt_q == '0) && !ack_s;
`else
  assign hold_done = (cnt_q == '0);
  assign gap_done  = (cnt_q == '0);
`endif

  // Next-state, counter, data capture; req_ready is the only combinational output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_bus_d    = tx_bus_q;
    tx_en_d     = tx_en_q;
    grant_d     = grant_q;
    last_d      = last_q;
    req_ready_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = rst_i ? '0 : pick_onehot;
        if (|req_valid_i) begin
          state_d  = ST_HOLD;
          cnt_d    = HOLD_LOAD;
          tx_bus_d = req_word[pick_idx];
          tx_en_d  = 1'b1;
          grant_d  = pick_idx;
          last_d   = pick_idx;
        end
      end
      ST_HOLD: begin
        if (hold_done) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
          tx_en_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tx_bus_q <= '0;
      tx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      last_q   <= LAST_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_bus_q <= tx_bus_d;
      tx_en_q  <= tx_en_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  assign tx_bus_o    = tx_bus_q;
  assign tx_enable_o = tx_en_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Self-checking bench for sync_tx_arbiter: directed vectors, corner sequences and a
// randomized run against an age-based reference model of the word timing.
module tb_sync_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;
  localparam int G = 3;
  localparam int P = H + G + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   ready;
  logic [W-1:0]   bus;
  logic           en;
  logic [1:0]     gid;
  logic           busy;
`ifdef SYNC_TX_ARB_ACK_EN
  logic           ack = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  sync_tx_arbiter #(
    .NUM_REQ(N), .BUS_WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_ready_o (ready),
    .tx_bus_o    (bus),
    .tx_enable_o (en),
    .grant_id_o  (gid),
    .busy_o      (busy)
`ifdef SYNC_TX_ARB_ACK_EN
    ,
    .tx_ack_i    (ack)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_ready;
    int             exp_gid;
    logic [W-1:0]   exp_bus;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of cycle 1 after an accept; returns at the first IDLE cycle.
  task automatic check_word(input logic [W-1:0] exp_bus, input int exp_gid);
    for (int k = 1; k <= H + G; k++) begin
      chk("tx_enable", 32'(en), 32'(k <= H));
      chk("busy", 32'(busy), 32'd1);
      chk("tx_bus", 32'(bus), 32'(exp_bus));
      chk("grant_id", 32'(gid), 32'(exp_gid));
      chk("ready_not_idle", 32'(ready), 32'd0);
      @(negedge clk);
    end
    chk("tx_enable_idle", 32'(en), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("tx_bus_idle", 32'(bus), 32'(exp_bus));
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (((v >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int           age;
    int           m_last;
    int           m_gid;
    int           w;
    logic [W-1:0] m_bus;

    tbl[0] = '{4'b1010, 32'h13121110, 4'b0010, 1, 8'h11};
    tbl[1] = '{4'b1010, 32'h23222120, 4'b1000, 3, 8'h23};
    tbl[2] = '{4'b1010, 32'h33323130, 4'b0010, 1, 8'h31};
    tbl[3] = '{4'b0101, 32'h43424140, 4'b0100, 2, 8'h42};
    tbl[4] = '{4'b0011, 32'h53525150, 4'b0001, 0, 8'h50};
    tbl[5] = '{4'b1000, 32'h63626160, 4'b1000, 3, 8'h63};
    tbl[6] = '{4'b1001, 32'h73727170, 4'b0001, 0, 8'h70};
    tbl[7] = '{4'b0110, 32'h83828180, 4'b0010, 1, 8'h81};
    tbl[8] = '{4'b1111, 32'h93929190, 4'b0100, 2, 8'h92};

    // Reset values, with all requests pending during reset.
    rst   = 1'b1;
    valid = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    valid = '1;
    #1;
    chk("rst_tx_bus", 32'(bus), 32'd0);
    chk("rst_tx_enable", 32'(en), 32'd0);
    chk("rst_grant_id", 32'(gid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst   = 1'b0;
    valid = '0;
    data  = 32'h000000A5;
    @(negedge clk);
    chk("idle_no_req_ready", 32'(ready), 32'd0);
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    // Single requester 0: ready one cycle, then the full HOLD/GAP profile.
    valid = 4'b0001;
    #1;
    chk("single_ready", 32'(ready), 32'h1);
    @(negedge clk);
    valid = '0;
    check_word(8'hA5, 0);

    // Reset in the second HOLD cycle clears outputs without a clock edge.
    valid = 4'b1111;
    data  = 32'h44332211;
    #1;
    chk("pre_rst_ready", 32'(ready), 32'h2);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_enable", 32'(en), 32'd1);
    chk("pre_rst_bus", 32'(bus), 32'h22);
    rst = 1'b1;
    #1;
    chk("async_rst_enable", 32'(en), 32'd0);
    chk("async_rst_bus", 32'(bus), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    data = 32'hD3C2B1A0;
    #1;

    // All four requesting: rotation 0,1,2,3,0 with one word per period.
    for (int i = 0; i < 5; i++) begin
      w = i % N;
      #1;
      chk("rr_ready", 32'(ready), 32'd1 << w);
      @(negedge clk);
      check_word(W'(data >> (w * W)), w);
    end

    // Directed arbitration vectors; data is scrambled after accept to prove capture.
    for (int i = 0; i < 9; i++) begin
      valid = tbl[i].valid;
      data  = tbl[i].data;
      #1;
      chk("tbl_ready", 32'(ready), 32'(tbl[i].exp_ready));
      @(negedge clk);
      valid = '0;
      data  = ~data;
      check_word(tbl[i].exp_bus, tbl[i].exp_gid);
    end

    // Request arriving during GAP waits for IDLE, then is accepted immediately.
    valid = 4'b0001;
    data  = 32'h0000005A;
    #1;
    chk("gap_first_ready", 32'(ready), 32'h1);
    @(negedge clk);
    valid = '0;
    for (int k = 1; k <= H + G; k++) begin
      if (k == H + 1) begin
        valid = 4'b0010;
        data  = 32'h00003C00;
      end
      #1;
      chk("gap_ready_low", 32'(ready), 32'd0);
      chk("gap_enable", 32'(en), 32'(k <= H));
      @(negedge clk);
    end
    #1;
    chk("gap_idle_ready", 32'(ready), 32'h2);
    chk("gap_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    valid = '0;
    chk("gap_next_enable", 32'(en), 32'd1);
    chk("gap_next_bus", 32'(bus), 32'h3C);
    chk("gap_next_gid", 32'(gid), 32'd1);

    // Randomized traffic against the age-since-accept model.
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    age    = P;
    m_last = N - 1;
    m_gid  = 0;
    m_bus  = '0;
    for (int c = 0; c < 1500; c++) begin
      valid = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      data  = $urandom();
      #1;
      w = (age >= P) ? rr_pick(valid, m_last) : -1;
      chk("rnd_ready", 32'(ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("rnd_enable", 32'(en), 32'(age >= 1 && age <= H));
      chk("rnd_busy", 32'(busy), 32'(age <= H + G));
      chk("rnd_bus", 32'(bus), 32'(m_bus));
      chk("rnd_gid", 32'(gid), 32'(m_gid));
      if (w >= 0) begin
        m_bus  = W'(data >> (w * W));
        m_gid  = w;
        m_last = w;
        age    = 1;
      end else if (age < P) begin
        age++;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
